ps2_mouse_receiver: RTL and testbench

Receive-only PS/2 mouse front end that feeds the microcontroller's memory-mapped mouse inputs. It samples the open-drain PS2_CLK/PS2_DATA lines and decodes 11-bit frames into standard 3-byte movement packets. It integrates the movements into a clamped cursor position on MouseData and emits a single-cycle MOUSECLICK pulse on each left-button press. Stream mode (0xF4) is enabled by the separate ps2_host_tx block; this block never drives the bus.

---
 rtl/ps2_mouse_receiver.sv | 178 +++++++++++++++++
 tb/tb_ps2_mouse_receiver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_receiver.sv
// Receive-only PS/2 mouse front end: synchronizes and filters the bus, decodes
// 11-bit frames into 3-byte packets and integrates movement into a clamped cursor.
module ps2_mouse_receiver #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 100000,
   parameter int XMAX    = 639,
   parameter int YMAX    = 479
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        PS2_CLK,
   input  logic        PS2_DATA,
   output logic [31:0] MouseData,
   output logic        MOUSECLICK,
   output logic        PACKET_VALID,
   output logic        FRAME_ERR
);
   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_meta, clk_sync, data_meta, data_sync;
   logic [FW-1:0] filt_cnt;
   logic          filt_level, filt_prev, fall;
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          parity_bit, byte_ready, byte_err;
   logic [TW-1:0] to_cnt;
   logic          timeout_hit;
   logic [1:0]    byte_idx;
   logic          b0_l, b0_xs, b0_ys, b0_xo, b0_yo, prev_l;
   logic [7:0]    b1;
   logic [15:0]   x_pos, y_pos, x_new, y_new;
   logic signed [17:0] dx, dy, x_sum, y_sum;

   // Lines idle high, so the synchronizers reset to 1 to avoid a false fall.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         clk_meta   <= 1'b1;
         clk_sync   <= 1'b1;
         data_meta  <= 1'b1;
         data_sync  <= 1'b1;
         filt_cnt   <= '0;
         filt_level <= 1'b1;
         filt_prev  <= 1'b1;
      end else begin
         clk_meta  <= PS2_CLK;
         clk_sync  <= clk_meta;
         data_meta <= PS2_DATA;
         data_sync <= data_meta;
         filt_prev <= filt_level;
         if (clk_sync == filt_level) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER - 1)) begin
            filt_level <= clk_sync;
            filt_cnt   <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = filt_prev & ~filt_level;
   assign timeout_hit = (to_cnt == TW'(TIMEOUT)) && !fall && (state != IDLE || byte_idx != 2'd0);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         to_cnt <= '0;
      end else if (fall) begin
         to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT)) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
         byte_ready <= 1'b0;
         byte_err   <= 1'b0;
      end else begin
         byte_ready <= 1'b0;
         byte_err   <= 1'b0;
         if (timeout_hit) begin
            state <= IDLE;
         end else if (fall) begin
            case (state)
               IDLE: if (!data_sync) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
               DATA: begin
                  shift   <= {data_sync, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  parity_bit <= data_sync;
                  state      <= STOP;
               end
               default: begin
                  if (data_sync && (^{shift, parity_bit})) byte_ready <= 1'b1;
                  else                                     byte_err   <= 1'b1;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // Cursor math in 18-bit signed so the sum can be clamped instead of wrapping.
   always_comb begin
      dx    = {{9{b0_xs}}, b0_xs, b1};
      dy    = {{9{b0_ys}}, b0_ys, shift};
      x_sum = $signed({2'b00, x_pos}) + dx;
      y_sum = $signed({2'b00, y_pos}) - dy;
      x_new = x_pos;
      y_new = y_pos;
      if (!b0_xo) begin
         if (x_sum[17])                     x_new = 16'd0;
         else if (x_sum[16:0] > 17'(XMAX))  x_new = 16'(XMAX);
         else                               x_new = x_sum[15:0];
      end
      if (!b0_yo) begin
         if (y_sum[17])                     y_new = 16'd0;
         else if (y_sum[16:0] > 17'(YMAX))  y_new = 16'(YMAX);
         else                               y_new = y_sum[15:0];
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         byte_idx     <= 2'd0;
         {b0_l, b0_xs, b0_ys, b0_xo, b0_yo} <= '0;
         b1           <= '0;
         prev_l       <= 1'b0;
         x_pos        <= '0;
         y_pos        <= '0;
         MOUSECLICK   <= 1'b0;
         PACKET_VALID <= 1'b0;
         FRAME_ERR    <= 1'b0;
      end else begin
         MOUSECLICK   <= 1'b0;
         PACKET_VALID <= 1'b0;
         FRAME_ERR    <= byte_err | timeout_hit;
         if (byte_err || timeout_hit) begin
            byte_idx <= 2'd0;
         end else if (byte_ready) begin
            case (byte_idx)
               2'd0: if (shift[3]) begin
                  {b0_yo, b0_xo, b0_ys, b0_xs} <= shift[7:4];
                  b0_l     <= shift[0];
                  byte_idx <= 2'd1;
               end
               2'd1: begin
                  b1       <= shift;
                  byte_idx <= 2'd2;
               end
               default: begin
                  x_pos        <= x_new;
                  y_pos        <= y_new;
                  PACKET_VALID <= 1'b1;
                  MOUSECLICK   <= b0_l & ~prev_l;
                  prev_l       <= b0_l;
                  byte_idx     <= 2'd0;
               end
            endcase
         end
      end
   end

   assign MouseData = {x_pos, y_pos};
endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// Directed bench: drives PS/2 frames and checks decoded packets and errors
// against a queue of hand-computed expectations popped by a separate monitor.
module tb_ps2_mouse_receiver;
   localparam int FILTER  = 8;
   localparam int TIMEOUT = 2000;
   localparam int HALF    = 20;

   typedef struct packed {
      logic        err;
      logic [15:0] x;
      logic [15:0] y;
      logic        click;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [31:0] mouse_data;
   logic        mouse_click, packet_valid, frame_err;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   ps2_mouse_receiver #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .XMAX(639), .YMAX(479)) dut (
      .CLK(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
      .MouseData(mouse_data), .MOUSECLICK(mouse_click),
      .PACKET_VALID(packet_valid), .FRAME_ERR(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic v, input bit glitch);
      ps2_data = v;
      wait_cyc(6);
      if (glitch) begin
         ps2_clk = 1'b0;
         wait_cyc(FILTER - 1);
         ps2_clk = 1'b1;
      end
      wait_cyc(HALF - 6);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   // Sends bits first..last of the frame; glitch lands in the high phase of data bit 3.
   task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch,
                            input int first, input int last);
      logic [10:0] bits;
      logic        par;
      par  = bad_par ? (^b) : ~(^b);
      bits = {1'b1, par, b, 1'b0};
      for (int i = first; i <= last; i++) send_bit(bits[i], glitch && (i == 4));
      ps2_data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic send_pkt(input logic [7:0] b0, b1, b2, input bit glitch,
                           input logic [15:0] x, y, input logic click);
      exp_q.push_back('{err: 1'b0, x: x, y: y, click: click});
      send_byte(b0, 1'b0, 1'b0, 0, 10);
      send_byte(b1, 1'b0, glitch, 0, 10);
      send_byte(b2, 1'b0, 1'b0, 0, 10);
      wait_cyc(60);
      $display("packet %02h %02h %02h sent, expect X=%0d Y=%0d click=%0b", b0, b1, b2, x, y, click);
   endtask

   task automatic push_err();
      exp_q.push_back('{err: 1'b1, x: 16'd0, y: 16'd0, click: 1'b0});
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_mousedata"}, mouse_data, 32'd0);
      chk({tag, "_click"}, {31'd0, mouse_click}, 32'd0);
      chk({tag, "_valid"}, {31'd0, packet_valid}, 32'd0);
      chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (packet_valid || frame_err) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event valid=%0b err=%0b expected=none", packet_valid, frame_err);
            end else begin
               mon_e = exp_q.pop_front();
               chk("event_kind_err", {31'd0, frame_err}, {31'd0, mon_e.err});
               if (!mon_e.err) begin
                  chk("packet_valid", {31'd0, packet_valid}, 32'd1);
                  chk("cursor_x", {16'd0, mouse_data[31:16]}, {16'd0, mon_e.x});
                  chk("cursor_y", {16'd0, mouse_data[15:0]}, {16'd0, mon_e.y});
                  chk("mouseclick", {31'd0, mouse_click}, {31'd0, mon_e.click});
               end
            end
         end else if (mouse_click) begin
            chk("click_without_packet", {31'd0, mouse_click}, 32'd0);
         end
      end
   end

   initial begin
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(2);
      chk_reset_state("reset");

      send_pkt(8'h08, 8'h0A, 8'h05, 1'b0, 16'd10, 16'd0, 1'b0);
      send_pkt(8'h28, 8'h00, 8'hF6, 1'b0, 16'd10, 16'd10, 1'b0);
      send_pkt(8'h19, 8'hF0, 8'h00, 1'b0, 16'd0, 16'd10, 1'b1);
      send_pkt(8'h19, 8'hF0, 8'h00, 1'b0, 16'd0, 16'd10, 1'b0);

      send_pkt(8'h08, 8'h7F, 8'h00, 1'b0, 16'd127, 16'd10, 1'b0);
      send_pkt(8'h08, 8'h7F, 8'h00, 1'b0, 16'd254, 16'd10, 1'b0);
      send_pkt(8'h08, 8'h7F, 8'h00, 1'b0, 16'd381, 16'd10, 1'b0);
      send_pkt(8'h08, 8'h7F, 8'h00, 1'b0, 16'd508, 16'd10, 1'b0);
      send_pkt(8'h08, 8'h7F, 8'h00, 1'b0, 16'd635, 16'd10, 1'b0);
      send_pkt(8'h08, 8'h7F, 8'h00, 1'b0, 16'd639, 16'd10, 1'b0);
      send_pkt(8'h08, 8'h7F, 8'h00, 1'b0, 16'd639, 16'd10, 1'b0);
      send_pkt(8'h58, 8'hFF, 8'h00, 1'b0, 16'd639, 16'd10, 1'b0);

      // Bad parity on byte 1 aborts the packet; the next one decodes normally.
      push_err();
      send_byte(8'h08, 1'b0, 1'b0, 0, 10);
      send_byte(8'h05, 1'b1, 1'b0, 0, 10);
      wait_cyc(60);
      $display("parity-corrupted byte sent, expect one frame error");
      send_pkt(8'h18, 8'hFE, 8'h01, 1'b0, 16'd637, 16'd9, 1'b0);

      // Stall mid-packet past the timeout.
      push_err();
      send_byte(8'h08, 1'b0, 1'b0, 0, 10);
      send_byte(8'h05, 1'b0, 1'b0, 0, 10);
      wait_cyc(TIMEOUT + 100);
      $display("partial packet stalled, expect timeout frame error");
      send_pkt(8'h18, 8'hFD, 8'h00, 1'b0, 16'd634, 16'd9, 1'b0);

      send_pkt(8'h09, 8'h02, 8'h00, 1'b1, 16'd636, 16'd9, 1'b1);

      // Reset mid-frame; the rest of that frame is all ones so it cannot look like a start bit.
      send_byte(8'h08, 1'b0, 1'b0, 0, 10);
      send_byte(8'hFF, 1'b0, 1'b0, 0, 2);
      rst = 1'b1;
      wait_cyc(3);
      chk_reset_state("midframe_reset");
      rst = 1'b0;
      $display("reset asserted mid-frame, outputs cleared");
      send_byte(8'hFF, 1'b0, 1'b0, 3, 10);
      wait_cyc(60);
      send_pkt(8'h09, 8'h05, 8'h00, 1'b0, 16'd5, 16'd0, 1'b1);

      wait_cyc(200);
      chk("pending_expectations", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
